sram_rw_port_ctrl: RTL and testbench

- Initiator-side controller for a single-port masked SRAM macro (512 x 40, 10 write-mask segments of 4 bits each, 1-cycle read latency).
- Arbitrates independent write and read request channels onto the one RW port.
- Optionally zero-initialises the whole array after reset.
- Returns read data on a valid/ready response channel. A holding register keeps a response stable under backpressure, because the macro's output changes whenever its row is later written.

---
 rtl/sram_rw_port_ctrl_pkg.sv | 30 +++
 rtl/sram_rw_port_ctrl_resp_hold.sv | 53 +++++
 rtl/sram_rw_port_ctrl.sv | 114 +++++++++++
 tb/tb_sram_rw_port_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_rw_port_ctrl_pkg.sv
// sram_rw_port_ctrl_pkg : shared types and geometry helpers for the SRAM port controller
// rev 1.0
`default_nettype none

package sram_rw_port_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    RUN  = 2'd2
  } ctrl_state_t;

  localparam int unsigned SRAM_ADDR_W   = 9;
  localparam int unsigned SRAM_DATA_W   = 40;
  localparam int unsigned SRAM_MASK_SEG = 10;

  function automatic int unsigned mask_gran(input int unsigned data_w, input int unsigned mask_seg);
    return data_w / mask_seg;
  endfunction

  function automatic int unsigned depth(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

  localparam int unsigned MASK_GRAN = mask_gran(SRAM_DATA_W, SRAM_MASK_SEG);
  localparam int unsigned DEPTH     = depth(SRAM_ADDR_W);

endpackage

`default_nettype wire

// File: rtl/sram_rw_port_ctrl_resp_hold.sv
// sram_resp_hold : read-response stage with a holding register for backpressure
// rev 1.0
`default_nettype none

module sram_resp_hold #(
  parameter int unsigned DATA_W = 40
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              issue_read,
  input  logic              resp_ready,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_data,
  output logic              can_issue
);

  logic              s1_valid_q,   s1_valid_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_data_q,  hold_data_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q   <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  always_comb begin
    s1_valid_d   = issue_read;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (hold_valid_q) begin
      if (resp_ready) hold_valid_d = 1'b0;
    end else if (s1_valid_q && !resp_ready) begin
      // Macro output is only stable for one cycle; a later write to the row would corrupt it.
      hold_valid_d = 1'b1;
      hold_data_d  = sram_rdata;
    end
  end

  assign resp_valid = s1_valid_q || hold_valid_q;
  assign resp_data  = hold_valid_q ? hold_data_q : sram_rdata;
  assign can_issue  = !hold_valid_q && (!s1_valid_q || resp_ready);

endmodule

`default_nettype wire

// File: rtl/sram_rw_port_ctrl.sv
// sram_rw_port_ctrl : write/read arbiter and init sweeper for a single-port masked SRAM
// rev 1.0
`default_nettype none

module sram_rw_port_ctrl
  import sram_rw_port_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W        = SRAM_ADDR_W,
  parameter int unsigned DATA_W        = SRAM_DATA_W,
  parameter int unsigned MASK_SEG      = SRAM_MASK_SEG,
  parameter bit          INIT_ON_RESET = 1'b1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                w_valid,
  output logic                w_ready,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [MASK_SEG-1:0] w_mask,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [DATA_W-1:0]   resp_data,
  output logic                init_done,
  output logic                sram_en,
  output logic                sram_wmode,
  output logic [ADDR_W-1:0]   sram_addr,
  output logic [MASK_SEG-1:0] sram_wmask,
  output logic [DATA_W-1:0]   sram_wdata,
  input  logic [DATA_W-1:0]   sram_rdata
);

  localparam int unsigned MASK_GRAN_L = mask_gran(DATA_W, MASK_SEG);
  localparam int unsigned DEPTH_L     = depth(ADDR_W);

  if (MASK_GRAN_L * MASK_SEG != DATA_W) begin : g_gran_check
    $error("DATA_W must be an exact multiple of MASK_SEG");
  end

  ctrl_state_t       state_q, state_d;
  logic [ADDR_W-1:0] cnt_q,   cnt_d;
  logic              issue_read;
  logic              can_issue;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    w_ready    = 1'b0;
    r_ready    = 1'b0;
    init_done  = 1'b0;
    issue_read = 1'b0;
    sram_en    = 1'b0;
    sram_wmode = 1'b0;
    sram_addr  = '0;
    sram_wmask = '0;
    sram_wdata = '0;
    case (state_q)
      IDLE: state_d = INIT_ON_RESET ? INIT : RUN;
      INIT: begin
        sram_en    = 1'b1;
        sram_wmode = 1'b1;
        sram_addr  = cnt_q;
        sram_wmask = '1;
        cnt_d      = cnt_q + ADDR_W'(1);
        if (cnt_q == ADDR_W'(DEPTH_L - 1)) state_d = RUN;
      end
      RUN: begin
        init_done = 1'b1;
        w_ready   = 1'b1;
        r_ready   = !w_valid && can_issue;
        if (w_valid) begin
          sram_en    = 1'b1;
          sram_wmode = 1'b1;
          sram_addr  = w_addr;
          sram_wmask = w_mask;
          sram_wdata = w_data;
        end else if (r_valid && r_ready) begin
          issue_read = 1'b1;
          sram_en    = 1'b1;
          sram_addr  = r_addr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  sram_resp_hold #(
    .DATA_W(DATA_W)
  ) u_resp_hold (
    .clock      (clock),
    .reset_n    (reset_n),
    .issue_read (issue_read),
    .resp_ready (resp_ready),
    .sram_rdata (sram_rdata),
    .resp_valid (resp_valid),
    .resp_data  (resp_data),
    .can_issue  (can_issue)
  );

endmodule

`default_nettype wire

// File: tb/tb_sram_rw_port_ctrl.sv
// tb_sram_rw_port_ctrl : directed + random bench with a write-through SRAM macro model
// rev 1.0
`default_nettype none

module tb_sram_rw_port_ctrl;
  import sram_rw_port_ctrl_pkg::*;

  localparam int AW = 9;
  localparam int DW = 40;
  localparam int MS = 10;

  logic          clock, reset_n;
  logic          w_valid, w_ready, r_valid, r_ready;
  logic [AW-1:0] w_addr, r_addr, sram_addr;
  logic [DW-1:0] w_data, resp_data, sram_wdata, sram_rdata;
  logic [MS-1:0] w_mask, sram_wmask;
  logic          resp_valid, resp_ready, init_done, sram_en, sram_wmode;

  sram_rw_port_ctrl #(
    .ADDR_W(AW), .DATA_W(DW), .MASK_SEG(MS), .INIT_ON_RESET(1'b1)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .init_done(init_done),
    .sram_en(sram_en), .sram_wmode(sram_wmode), .sram_addr(sram_addr),
    .sram_wmask(sram_wmask), .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] data,
                                          input logic [MS-1:0] mask);
    logic [DW-1:0] r;
    r = old;
    for (int s = 0; s < MS; s++)
      if (mask[s]) r[s*MASK_GRAN +: MASK_GRAN] = data[s*MASK_GRAN +: MASK_GRAN];
    return r;
  endfunction

  // Macro: output register follows the last accessed row, including writes.
  logic [DW-1:0] mem [0:DEPTH-1];
  initial for (int i = 0; i < DEPTH; i++) mem[i] = DW'(64'hA5A5_5A5A_C3C3 ^ 64'(i));
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) begin
        mem[sram_addr] <= merge(mem[sram_addr], sram_wdata, sram_wmask);
        sram_rdata     <= merge(mem[sram_addr], sram_wdata, sram_wmask);
      end else begin
        sram_rdata <= mem[sram_addr];
      end
    end
  end

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] shadow [0:DEPTH-1];
  logic [DW-1:0] exp_q [$];
  int            age = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_idle();
    w_valid = 1'b0; r_valid = 1'b0; resp_ready = 1'b1;
    w_addr = '0; r_addr = '0; w_data = '0; w_mask = '0;
  endtask

  // One RUN-phase cycle: compare against the reference, then advance the reference.
  task automatic run_cycle();
    logic          exp_rr;
    logic [60:0]   exp_port;
    @(negedge clock);
    exp_rr = !w_valid && (exp_q.size() == 0 || (age == 0 && resp_ready));
    exp_port = '0;
    if (w_valid) exp_port = {1'b1, 1'b1, w_addr, w_mask, w_data};
    else if (r_valid && exp_rr) exp_port = {1'b1, 1'b0, r_addr, {MS{1'b0}}, {DW{1'b0}}};
    chk("init_done", 64'(init_done), 64'd1);
    chk("w_ready", 64'(w_ready), 64'd1);
    chk("r_ready", 64'(r_ready), 64'(exp_rr));
    chk("resp_valid", 64'(resp_valid), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) chk("resp_data", 64'(resp_data), 64'(exp_q[0]));
    chk("sram_port", 64'({sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}), 64'(exp_port));
    if (exp_q.size() != 0) begin
      if (resp_ready) begin
        void'(exp_q.pop_front());
        age = 0;
      end else begin
        age++;
      end
    end
    if (r_valid && exp_rr) exp_q.push_back(shadow[r_addr]);
    if (w_valid) shadow[w_addr] = merge(shadow[w_addr], w_data, w_mask);
    @(posedge clock); #1;
  endtask

  // Called right after reset release: one IDLE cycle then the full zero sweep.
  task automatic init_sweep();
    w_valid = 1'b1; r_valid = 1'b1; w_addr = 9'h055; r_addr = 9'h0AA;
    w_data = '1; w_mask = '1;
    @(negedge clock);
    chk("idle_sram_en", 64'(sram_en), 64'd0);
    chk("idle_init_done", 64'(init_done), 64'd0);
    chk("idle_resp_valid", 64'(resp_valid), 64'd0);
    @(posedge clock); #1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clock);
      chk("init_port", 64'({sram_en, sram_wmode, sram_addr, sram_wmask, sram_wdata}),
          64'({1'b1, 1'b1, AW'(i), {MS{1'b1}}, {DW{1'b0}}}));
      chk("init_w_ready", 64'(w_ready), 64'd0);
      chk("init_r_ready", 64'(r_ready), 64'd0);
      chk("init_done_low", 64'(init_done), 64'd0);
      @(posedge clock); #1;
    end
    for (int i = 0; i < DEPTH; i++) shadow[i] = '0;
    exp_q.delete();
    age = 0;
    set_idle();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MS-1:0] m);
    w_valid = 1'b1; w_addr = a; w_data = d; w_mask = m; r_valid = 1'b0;
    run_cycle();
    w_valid = 1'b0;
  endtask

  task automatic rd(input logic [AW-1:0] a);
    r_valid = 1'b1; r_addr = a; w_valid = 1'b0;
    run_cycle();
    r_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    set_idle();
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_outputs", 64'({resp_valid, w_ready, r_ready, init_done, sram_en}), 64'd0);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
    init_sweep();

    // Read of the top row after the sweep returns zero.
    rd(9'h1FF);
    run_cycle();

    // Partial-mask write clears only the lowest nibble.
    wr(9'h005, 40'hFF_FFFF_FFFF, 10'h3FF);
    wr(9'h005, 40'h0, 10'h001);
    wr(9'h006, 40'h12_3456_789A, 10'h000);
    rd(9'h005);
    rd(9'h006);
    run_cycle();

    // Simultaneous write and read: write wins, read follows next cycle.
    w_valid = 1'b1; w_addr = 9'h007; w_data = 40'h77; w_mask = 10'h3FF;
    r_valid = 1'b1; r_addr = 9'h007;
    run_cycle();
    w_valid = 1'b0;
    run_cycle();
    r_valid = 1'b0;
    run_cycle();

    // Backpressured response must survive an overwrite of its row.
    wr(9'h010, 40'hAB, 10'h3FF);
    resp_ready = 1'b0;
    rd(9'h010);
    wr(9'h010, 40'hCD, 10'h3FF);
    r_valid = 1'b1; r_addr = 9'h011;
    run_cycle();
    run_cycle();
    run_cycle();
    resp_ready = 1'b1;
    run_cycle();
    run_cycle();
    r_valid = 1'b0;
    run_cycle();

    // Streaming reads at full rate.
    for (int i = 1; i <= 4; i++) wr(AW'(i), DW'(64'h1000 * i + i), 10'h3FF);
    for (int i = 1; i <= 4; i++) rd(AW'(i));
    run_cycle();

    // Random traffic on a small address window to force collisions.
    for (int n = 0; n < 400; n++) begin
      w_valid    = ($urandom_range(0, 3) == 0);
      r_valid    = ($urandom_range(0, 1) == 1);
      resp_ready = ($urandom_range(0, 9) < 7);
      w_addr     = AW'($urandom_range(0, 15));
      r_addr     = AW'($urandom_range(0, 15));
      w_data     = DW'({$urandom(), $urandom()});
      w_mask     = MS'($urandom());
      run_cycle();
    end
    set_idle();
    run_cycle();
    run_cycle();

    // Reset with a held response pending drops it and restarts the sweep.
    resp_ready = 1'b0;
    rd(9'h010);
    run_cycle();
    w_valid = 1'b1; w_addr = 9'h003; w_data = 40'h5; w_mask = 10'h3FF;
    #1;
    reset_n = 1'b0;
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_sram_en", 64'(sram_en), 64'd0);
    chk("rst_init_done", 64'(init_done), 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    init_sweep();
    rd(9'h010);
    run_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
